// File: rtl/framebuffer_writer_if.sv
// Bus interfaces for the framebuffer upload path; both are clocked by the owner's clk.
// test_freeze lets a bus model hold the burst engine in IDLE.
interface burst_bus_if;
    logic [20:0] addr;
    logic        cmd;
    logic        cmd_en;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic        test_freeze;

    modport master (input test_freeze, output addr, cmd, cmd_en, wr_data, data_mask);
    modport slave  (input addr, cmd, cmd_en, wr_data, data_mask, output test_freeze);
endinterface

interface debug_bus_if;
    logic [15:0] addr;
    logic        write_enable;
    logic [7:0]  write_data;

    modport master (output addr, write_enable, write_data);
    modport slave  (input addr, write_enable, write_data);
endinterface

// File: rtl/framebuffer_writer.sv
// Packs host pixel bytes into 64-bit words, queues them in an 8-deep FIFO and
// writes them to SDRAM as 4-beat bursts (first byte lands in wr_data[63:56]).
module framebuffer_writer (
    input  logic        clk,
    input  logic        reset,
    burst_bus_if.master bus,
    debug_bus_if.slave  dbus,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_BEAT3} state_e;

    state_e      state_q, state_d;
    logic [20:0] wr_addr_q, wr_addr_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [63:0] pack_q, pack_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  wptr_q, wptr_d;
    logic [2:0]  rptr_q, rptr_d;
    logic        flush_req_q, flush_req_d;
    logic        flush_pend_q, flush_pend_d;
    logic        overflow_q, overflow_d;

    logic [63:0] fifo_data [8];
    logic [7:0]  fifo_mask [8];

    logic        push, pop, launch;
    logic [63:0] push_data;
    logic [7:0]  push_mask;
    logic [63:0] pk;

    logic reg_sel, byte_wr, ctrl_wr, addr_wr, byte_drop;

    assign reg_sel   = dbus.write_enable && (dbus.addr[15:8] == 8'h04);
    assign byte_wr   = reg_sel && (dbus.addr[7:0] == 8'd4);
    assign ctrl_wr   = reg_sel && (dbus.addr[7:0] == 8'd5);
    assign addr_wr   = reg_sel && (dbus.addr[7:0] >= 8'd1) && (dbus.addr[7:0] <= 8'd3);
    assign byte_drop = byte_wr && (count_q == 4'd8) && (bidx_q == 3'd7);

    assign launch = (state_q == S_IDLE) && !bus.test_freeze &&
                    ((count_q >= 4'd4) || (flush_pend_q && (count_q != 4'd0)));
    // Beats 1..3 pop only if a word is there; otherwise they are padding.
    assign pop    = launch || ((state_q != S_IDLE) && (count_q != 4'd0));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_BEAT1;
            S_BEAT1: state_d = S_BEAT2;
            S_BEAT2: state_d = S_BEAT3;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: bus outputs ----------------
    always_comb begin
        bus.cmd_en    = launch;
        bus.cmd       = launch;
        bus.addr      = launch ? wr_addr_q : 21'd0;
        bus.wr_data   = 64'd0;
        bus.data_mask = 8'h00;
        if (pop) begin
            bus.wr_data   = fifo_data[rptr_q];
            bus.data_mask = fifo_mask[rptr_q];
        end else if (state_q != S_IDLE) begin
            bus.data_mask = 8'hFF;
        end
    end

    // ---------------- packer, registers, flush ----------------
    always_comb begin
        pack_d       = pack_q;
        bidx_d       = bidx_q;
        wr_addr_d    = wr_addr_q;
        overflow_d   = overflow_q;
        flush_req_d  = flush_req_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_data    = 64'd0;
        push_mask    = 8'h00;

        pk = pack_q;
        pk[{~bidx_q, 3'b000} +: 8] = dbus.write_data;

        if (flush_pend_q && (state_q == S_IDLE) && (count_q == 4'd0))
            flush_pend_d = 1'b0;

        if (byte_drop) begin
            overflow_d = 1'b1;
        end else if (byte_wr) begin
            if (bidx_q == 3'd7) begin
                push      = 1'b1;
                push_data = pk;
                pack_d    = 64'd0;
                bidx_d    = 3'd0;
            end else begin
                pack_d = pk;
                bidx_d = bidx_q + 3'd1;
            end
        end

        // Flush acts one cycle after the control write; a partial word waits for FIFO room.
        if (flush_req_q) begin
            if (bidx_d == 3'd0) begin
                flush_req_d  = 1'b0;
                flush_pend_d = 1'b1;
            end else if (count_q != 4'd8) begin
                push         = 1'b1;
                push_data    = pack_d;
                push_mask    = 8'hFF >> bidx_d;
                pack_d       = 64'd0;
                bidx_d       = 3'd0;
                flush_req_d  = 1'b0;
                flush_pend_d = 1'b1;
            end
        end

        if (ctrl_wr) begin
            if (dbus.write_data[0]) flush_req_d = 1'b1;
            if (dbus.write_data[1]) overflow_d  = 1'b0;
        end

        if (addr_wr) begin
            pack_d = 64'd0;
            bidx_d = 3'd0;
            // The address captured at burst start must not move under the burst.
            if ((state_q == S_IDLE) && !launch) begin
                case (dbus.addr[1:0])
                    2'd1:    wr_addr_d[20:16] = dbus.write_data[4:0];
                    2'd2:    wr_addr_d[15:8]  = dbus.write_data;
                    default: wr_addr_d[7:0]   = dbus.write_data;
                endcase
            end
        end

        if (state_q == S_BEAT3) wr_addr_d = wr_addr_q + 21'd16;
    end

    always_comb begin
        count_d = count_q + {3'b000, push} - {3'b000, pop};
        wptr_d  = wptr_q + {2'b00, push};
        rptr_d  = rptr_q + {2'b00, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_q    <= 21'd0;
            bidx_q       <= 3'd0;
            pack_q       <= 64'd0;
            count_q      <= 4'd0;
            wptr_q       <= 3'd0;
            rptr_q       <= 3'd0;
            flush_req_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            bidx_q       <= bidx_d;
            pack_q       <= pack_d;
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            flush_req_q  <= flush_req_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr_q] <= push_data;
            fifo_mask[wptr_q] <= push_mask;
        end
    end

    assign busy     = (count_q != 4'd0) | (bidx_q != 3'd0) | (state_q != S_IDLE) | flush_pend_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: a byte/word/burst-level model predicts
// each burst; a negedge monitor compares whatever the DUT puts on the burst bus.
module tb_framebuffer_writer;

    logic clk = 1'b0;
    logic reset;
    logic busy, overflow;

    burst_bus_if bus ();
    debug_bus_if dbus ();

    framebuffer_writer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbus     (dbus),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] d; logic [7:0] m; } word_t;
    typedef struct packed {
        logic [20:0]      addr;
        logic [3:0][63:0] d;
        logic [3:0][7:0]  m;
    } burst_t;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  m_pack [$];
    word_t       m_fifo [$];
    burst_t      exp_q  [$];
    logic [20:0] m_addr = 21'd0;
    bit          m_ovf = 1'b0;
    bit          m_frozen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic void m_pack_word();
        word_t w;
        w.d = '0;
        w.m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < m_pack.size()) w.d[63-8*i -: 8] = m_pack[i];
            else                   w.m[7-i] = 1'b1;
        end
        m_fifo.push_back(w);
        m_pack.delete();
    endfunction

    function automatic void make_bursts(input bit fl);
        while (!m_frozen && (m_fifo.size() >= 4 || (fl && m_fifo.size() > 0))) begin
            burst_t b;
            b.addr = m_addr;
            for (int k = 0; k < 4; k++) begin
                if (m_fifo.size() > 0) begin
                    word_t w;
                    w = m_fifo.pop_front();
                    b.d[k] = w.d;
                    b.m[k] = w.m;
                end else begin
                    b.d[k] = '0;
                    b.m[k] = 8'hFF;
                end
            end
            exp_q.push_back(b);
            m_addr = m_addr + 21'd16;
        end
    endfunction

    // monitor: one burst = launch cycle plus three beat cycles
    burst_t cur;
    int     mon_beat = 0;
    always @(negedge clk) begin
        if (reset) begin
            mon_beat = 0;
        end else if (mon_beat == 0) begin
            if (bus.cmd_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_burst: got addr %h expected no burst", bus.addr);
                end else begin
                    cur = exp_q.pop_front();
                    chk("burst_addr", bus.addr, cur.addr);
                    chk("burst_cmd", bus.cmd, 1);
                    chk("beat0_data", bus.wr_data, cur.d[0]);
                    chk("beat0_mask", bus.data_mask, cur.m[0]);
                    mon_beat = 1;
                end
            end
        end else begin
            chk("beat_cmd_en", bus.cmd_en, 0);
            chk($sformatf("beat%0d_data", mon_beat), bus.wr_data, cur.d[mon_beat]);
            chk($sformatf("beat%0d_mask", mon_beat), bus.data_mask, cur.m[mon_beat]);
            mon_beat = (mon_beat == 3) ? 0 : mon_beat + 1;
        end
    end

    // all stimulus tasks start and end 1 time unit after a rising edge
    task automatic wr_page(input logic [7:0] page, input logic [7:0] idx, input logic [7:0] data);
        dbus.write_enable = 1'b1;
        dbus.addr         = {page, idx};
        dbus.write_data   = data;
        @(posedge clk); #1;
        dbus.write_enable = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] idx, input logic [7:0] data);
        wr_page(8'h04, idx, data);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_addr(input logic [20:0] a);
        wr_reg(8'd1, {3'b000, a[20:16]});
        wr_reg(8'd2, a[15:8]);
        wr_reg(8'd3, a[7:0]);
        m_addr = a;
        m_pack.delete();
    endtask

    task automatic wr_byte(input logic [7:0] b);
        if (m_fifo.size() == 8 && m_pack.size() == 7) begin
            m_ovf = 1'b1;
        end else begin
            m_pack.push_back(b);
            if (m_pack.size() == 8) begin
                m_pack_word();
                make_bursts(1'b0);
            end
        end
        wr_reg(8'd4, b);
    endtask

    task automatic flush();
        if (m_pack.size() > 0) m_pack_word();
        make_bursts(1'b1);
        wr_reg(8'd5, 8'h01);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_pack.delete();
        m_fifo.delete();
        m_addr = 21'd0;
        m_ovf  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dbus.write_enable = 1'b0;
        dbus.addr = 16'h0;
        dbus.write_data = 8'h0;
        bus.test_freeze = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cmd_en", bus.cmd_en, 0);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_mask", bus.data_mask, 0);
        chk("rst_wr_addr", dut.wr_addr_q, 0);
        chk("rst_count", dut.count_q, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 32 sequential bytes: one full burst
        set_addr(21'h000100);
        wr_page(8'h05, 8'd4, 8'h55);
        chk("other_page_ignored", dut.bidx_q, 0);
        for (int i = 0; i < 32; i++) begin
            wr_byte(i[7:0]);
            if (i == 7) chk("word_visible", dut.count_q, 1);
        end
        @(negedge clk);
        chk("burst_latency", bus.cmd_en, 1);
        wait_idle(20);
        chk("wr_addr_after", dut.wr_addr_q, 21'h000110);
        chk("s1_drained", exp_q.size(), 0);

        // 10 bytes + flush: partial word and padding beats
        do_reset();
        set_addr(21'h000100);
        for (int i = 0; i < 10; i++) wr_byte(8'hA0 + i[7:0]);
        flush();
        @(negedge clk);
        chk("flush_lat_push", bus.cmd_en, 0);
        @(negedge clk);
        chk("flush_lat_burst", bus.cmd_en, 1);
        wait_idle(30);
        chk("s2_drained", exp_q.size(), 0);

        // 72 bytes back-to-back: two bursts, 9th word stays queued
        do_reset();
        set_addr(21'h000100);
        for (int i = 0; i < 72; i++) wr_byte(i[7:0]);
        cyc(10);
        chk("s3_busy", busy, 1);
        chk("s3_overflow", overflow, 0);
        chk("s3_count", dut.count_q, 1);
        chk("s3_drained", exp_q.size(), 0);

        // address wrap at 2^21
        do_reset();
        set_addr(21'h1FFFF0);
        for (int i = 0; i < 64; i++) wr_byte(8'hFF - i[7:0]);
        wait_idle(30);
        chk("wrap_wr_addr", dut.wr_addr_q, m_addr);
        chk("s4_drained", exp_q.size(), 0);

        // reset during BEAT2
        do_reset();
        set_addr(21'h000040);
        for (int i = 0; i < 32; i++) wr_byte(i[7:0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_beat2", dut.state_q, 2);
        reset = 1'b1;
        exp_q.delete();
        m_pack.delete();
        m_fifo.delete();
        m_addr = 21'd0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", dut.count_q, 0);
        chk("midrst_wr_addr", dut.wr_addr_q, 0);
        chk("midrst_cmd_en", bus.cmd_en, 0);
        @(negedge clk);
        chk("midrst_cmd_en_hold", bus.cmd_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(5);
        chk("midrst_quiet", busy, 0);

        // stall: FSM frozen, FIFO fills, bytes dropped
        do_reset();
        bus.test_freeze = 1'b1;
        m_frozen = 1'b1;
        for (int i = 0; i < 80; i++) wr_byte(i[7:0] + 8'd1);
        cyc(3);
        chk("stall_overflow", overflow, m_ovf);
        chk("stall_count", dut.count_q, 8);
        chk("stall_busy", busy, 1);
        wr_reg(8'd5, 8'h02);
        chk("ovf_cleared", overflow, 0);
        bus.test_freeze = 1'b0;
        m_frozen = 1'b0;
        make_bursts(1'b0);
        flush();
        wait_idle(100);
        chk("s6_drained", exp_q.size(), 0);

        // randomized rounds
        do_reset();
        for (int r = 0; r < 5; r++) begin
            logic [31:0] a;
            int n;
            a = $urandom;
            n = $urandom_range(1, 45);
            set_addr(a[20:0]);
            for (int i = 0; i < n; i++) begin
                logic [31:0] v;
                v = $urandom;
                wr_byte(v[7:0]);
                if ($urandom_range(0, 3) == 0) cyc(1);
            end
            flush();
            wait_idle(300);
            chk("rnd_wr_addr", dut.wr_addr_q, m_addr);
            chk("rnd_drained", exp_q.size(), 0);
        end

        cyc(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
